// File: rtl/cpuif_passthrough_initiator_if.sv
// Bundle of command, response and passthrough request/ack signals
// for the passthrough CPU-interface initiator.
interface cpuif_passthrough_initiator_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // command port
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_is_wr;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic [DATA_WIDTH-1:0] cmd_biten;
    // response port
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_is_wr;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;
    logic                  stray_ack;
    // passthrough request/ack side
    logic                  cpuif_req;
    logic                  cpuif_req_is_wr;
    logic [ADDR_WIDTH-1:0] cpuif_addr;
    logic [DATA_WIDTH-1:0] cpuif_wr_data;
    logic [DATA_WIDTH-1:0] cpuif_wr_biten;
    logic                  cpuif_req_stall_wr;
    logic                  cpuif_req_stall_rd;
    logic                  cpuif_rd_ack;
    logic                  cpuif_rd_err;
    logic [DATA_WIDTH-1:0] cpuif_rd_data;
    logic                  cpuif_wr_ack;
    logic                  cpuif_wr_err;

    // initiator view
    modport master (
        input  cmd_valid, cmd_is_wr, cmd_addr, cmd_wdata, cmd_biten, rsp_ready,
        input  cpuif_req_stall_wr, cpuif_req_stall_rd,
        input  cpuif_rd_ack, cpuif_rd_err, cpuif_rd_data, cpuif_wr_ack, cpuif_wr_err,
        output cmd_ready, rsp_valid, rsp_is_wr, rsp_rdata, rsp_err, rsp_timeout, stray_ack,
        output cpuif_req, cpuif_req_is_wr, cpuif_addr, cpuif_wr_data, cpuif_wr_biten
    );

    // command source / responder view
    modport slave (
        output cmd_valid, cmd_is_wr, cmd_addr, cmd_wdata, cmd_biten, rsp_ready,
        output cpuif_req_stall_wr, cpuif_req_stall_rd,
        output cpuif_rd_ack, cpuif_rd_err, cpuif_rd_data, cpuif_wr_ack, cpuif_wr_err,
        input  cmd_ready, rsp_valid, rsp_is_wr, rsp_rdata, rsp_err, rsp_timeout, stray_ack,
        input  cpuif_req, cpuif_req_is_wr, cpuif_addr, cpuif_wr_data, cpuif_wr_biten
    );
endinterface

// File: rtl/cpuif_passthrough_initiator.sv
// Passthrough CPU-interface initiator: takes one command at a time, drives
// it onto the passthrough request, waits for the matching ack (or a bounded
// timeout) and returns the result on the response port. Every output is a
// register or a decode of the state register.
module cpuif_passthrough_initiator #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                           clk,
    input  logic                           arst_n,
    cpuif_passthrough_initiator_if.master  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    // counter must hold TIMEOUT_CYCLES: an acceptance on the last count
    // cycle leaves one more WAIT cycle before the timeout fires
    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]            r_state;
    logic                  r_alive;
    logic                  r_is_wr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_biten;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_rsp_is_wr;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;
    logic                  r_rsp_timeout;
    logic                  r_stray;

    logic       w_stall;
    logic       w_ack_match;
    logic       w_ack_other;
    logic       w_ack_any;
    logic       w_expired;
    logic       w_accept;
    logic       w_ack_take;
    logic       w_timeout;
    logic       w_stray;
    logic [1:0] w_state_nxt;

    // Qualify stall/ack against the held command type and pick the next state.
    always_comb begin
        w_stall     = r_is_wr ? bus.cpuif_req_stall_wr : bus.cpuif_req_stall_rd;
        w_ack_match = r_is_wr ? bus.cpuif_wr_ack : bus.cpuif_rd_ack;
        w_ack_other = r_is_wr ? bus.cpuif_rd_ack : bus.cpuif_wr_ack;
        w_ack_any   = bus.cpuif_rd_ack | bus.cpuif_wr_ack;
        w_expired   = (r_cnt >= CNT_LAST);
        w_accept    = (r_state == S_IDLE) & r_alive & bus.cmd_valid;
        w_ack_take  = (r_state == S_WAIT) & w_ack_match;
        // an ack or an acceptance on the final count cycle beats the timeout
        w_timeout   = w_expired & (((r_state == S_REQ) & w_stall) |
                                   ((r_state == S_WAIT) & ~w_ack_match));
        // only the matching ack in WAIT belongs to a transaction
        w_stray     = (r_state == S_WAIT) ? w_ack_other : w_ack_any;
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = S_REQ;
            S_REQ: begin
                if (!w_stall)       w_state_nxt = S_WAIT;
                else if (w_timeout) w_state_nxt = S_RESP;
            end
            S_WAIT: if (w_ack_take || w_timeout) w_state_nxt = S_RESP;
            S_RESP: if (bus.rsp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State, ready-after-reset flag, timeout counter and stray-ack pulse.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= S_IDLE;
            r_alive <= 1'b0;
            r_cnt   <= '0;
            r_stray <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_alive <= 1'b1;
            r_stray <= w_stray;
            if (w_accept)
                r_cnt <= '0;
            else if (r_state == S_REQ || r_state == S_WAIT)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    // Hold the accepted command for the whole request phase.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_is_wr <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_biten <= '0;
        end else if (w_accept) begin
            r_is_wr <= bus.cmd_is_wr;
            r_addr  <= bus.cmd_addr;
            r_wdata <= bus.cmd_wdata;
            r_biten <= bus.cmd_biten;
        end
    end

    // Capture the response from the matching ack or from the timeout.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_rsp_is_wr   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else if (w_ack_take) begin
            r_rsp_is_wr   <= r_is_wr;
            r_rsp_rdata   <= r_is_wr ? '0 : bus.cpuif_rd_data;
            r_rsp_err     <= r_is_wr ? bus.cpuif_wr_err : bus.cpuif_rd_err;
            r_rsp_timeout <= 1'b0;
        end else if (w_timeout) begin
            r_rsp_is_wr   <= r_is_wr;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b1;
            r_rsp_timeout <= 1'b1;
        end
    end

    assign bus.cmd_ready       = (r_state == S_IDLE) & r_alive;
    assign bus.rsp_valid       = (r_state == S_RESP);
    assign bus.rsp_is_wr       = r_rsp_is_wr;
    assign bus.rsp_rdata       = r_rsp_rdata;
    assign bus.rsp_err         = r_rsp_err;
    assign bus.rsp_timeout     = r_rsp_timeout;
    assign bus.stray_ack       = r_stray;
    assign bus.cpuif_req       = (r_state == S_REQ);
    assign bus.cpuif_req_is_wr = r_is_wr;
    assign bus.cpuif_addr      = r_addr;
    assign bus.cpuif_wr_data   = r_wdata;
    assign bus.cpuif_wr_biten  = r_biten;
endmodule

// File: tb/tb_cpuif_passthrough_initiator.sv
// Bench for cpuif_passthrough_initiator: a table of directed transactions,
// randomized transactions predicted by a timing model, and a reset sequence.
module tb_cpuif_passthrough_initiator;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int T  = 8;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    always #5 clk = ~clk;

    cpuif_passthrough_initiator_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    cpuif_passthrough_initiator #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk),
        .arst_n(arst_n),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        is_wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] biten;
        logic [31:0] rdata;     // responder read data
        logic        err;       // responder error flag
        int          stall;     // cycles the relevant stall is held from first req cycle
        int          dly;       // extra cycles after the first WAIT cycle before ack
        int          wait_c;    // cycles rsp_ready stays low in RESP
        bit          late;      // after a timeout, send a late ack
        int          wrong;     // offset of a wrong-type ack, -10 for none
        int          exp_rsp_off;  // first rsp_valid cycle, counted from first req cycle
        logic        exp_err;
        logic        exp_to;
        logic [31:0] exp_rdata;
    } vec_t;

    function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] be, input logic [31:0] rd, input logic e,
                                input int s, input int d, input int wc, input bit late,
                                input int wrong, input int ro, input logic ee,
                                input logic et, input logic [31:0] er);
        vec_t v;
        v.is_wr = w; v.addr = a; v.wdata = wd; v.biten = be; v.rdata = rd; v.err = e;
        v.stall = s; v.dly = d; v.wait_c = wc; v.late = late; v.wrong = wrong;
        v.exp_rsp_off = ro; v.exp_err = ee; v.exp_to = et; v.exp_rdata = er;
        return v;
    endfunction

    // Timing model: the window runs T cycles from the first req cycle; the request
    // is taken in the first unstalled cycle, the ack comes dly cycles after the
    // first WAIT cycle, and a coinciding ack wins over the timeout.
    function automatic vec_t predict(input vec_t v);
        vec_t r;
        int   to_off;
        int   ack_off;
        bit   good;
        r = v;
        ack_off = 0;
        if (v.stall > T - 1) begin
            good   = 1'b0;
            to_off = T - 1;
        end else begin
            to_off  = (v.stall + 1 > T - 1) ? v.stall + 1 : T - 1;
            ack_off = v.stall + 1 + v.dly;
            good    = (ack_off <= to_off);
        end
        r.exp_to      = !good;
        r.exp_rsp_off = good ? ack_off + 1 : to_off + 1;
        r.exp_err     = good ? v.err : 1'b1;
        r.exp_rdata   = (good && !v.is_wr) ? v.rdata : 32'h0;
        return r;
    endfunction

    task automatic idle_inputs();
        bus.cmd_valid = 1'b0; bus.cmd_is_wr = 1'b0; bus.cmd_addr = '0;
        bus.cmd_wdata = '0; bus.cmd_biten = '0; bus.rsp_ready = 1'b0;
        bus.cpuif_req_stall_wr = 1'b0; bus.cpuif_req_stall_rd = 1'b0;
        bus.cpuif_rd_ack = 1'b0; bus.cpuif_rd_err = 1'b0; bus.cpuif_rd_data = '0;
        bus.cpuif_wr_ack = 1'b0; bus.cpuif_wr_err = 1'b0;
    endtask

    // Apply one transaction cycle by cycle and check every output each cycle.
    task automatic run(input vec_t v);
        int  req_last, ack_off, late_off, resp_end, last;
        bit  good;
        good     = !v.exp_to;
        req_last = (v.stall < T - 1) ? v.stall : T - 1;
        ack_off  = good ? v.stall + 1 + v.dly : -10;
        late_off = (v.late && !good) ? v.exp_rsp_off + 1 : -10;
        resp_end = v.exp_rsp_off + v.wait_c;
        last     = resp_end + 1;
        if (late_off + 1 > last) last = late_off + 1;
        if (v.wrong + 1 > last)  last = v.wrong + 1;

        @(posedge clk); #1;
        bus.cmd_valid = 1'b1; bus.cmd_is_wr = v.is_wr; bus.cmd_addr = v.addr;
        bus.cmd_wdata = v.wdata; bus.cmd_biten = v.biten;
        @(negedge clk);
        chk("cmd_ready_idle", bus.cmd_ready, 1);
        chk("rsp_valid_idle", bus.rsp_valid, 0);

        for (int o = 0; o <= last; o++) begin
            @(posedge clk); #1;
            bus.cmd_valid = 1'b0;
            bus.cmd_addr  = $urandom; bus.cmd_wdata = $urandom; bus.cmd_biten = $urandom;
            if (v.is_wr) begin
                bus.cpuif_req_stall_wr = (o < v.stall);
                bus.cpuif_req_stall_rd = 1'($urandom_range(0, 1));
            end else begin
                bus.cpuif_req_stall_rd = (o < v.stall);
                bus.cpuif_req_stall_wr = 1'($urandom_range(0, 1));
            end
            bus.cpuif_rd_data = $urandom;
            bus.cpuif_rd_err  = 1'($urandom_range(0, 1));
            bus.cpuif_wr_err  = 1'($urandom_range(0, 1));
            bus.cpuif_rd_ack  = 1'b0;
            bus.cpuif_wr_ack  = 1'b0;
            if (o == ack_off) begin
                if (v.is_wr) begin
                    bus.cpuif_wr_ack = 1'b1; bus.cpuif_wr_err = v.err;
                end else begin
                    bus.cpuif_rd_ack = 1'b1; bus.cpuif_rd_err = v.err;
                    bus.cpuif_rd_data = v.rdata;
                end
            end
            if (o == late_off) begin
                if (v.is_wr) bus.cpuif_wr_ack = 1'b1;
                else         bus.cpuif_rd_ack = 1'b1;
            end
            if (o == v.wrong) begin
                if (v.is_wr) bus.cpuif_rd_ack = 1'b1;
                else         bus.cpuif_wr_ack = 1'b1;
            end
            bus.rsp_ready = (o == resp_end) ||
                            (o < v.exp_rsp_off && $urandom_range(0, 1) == 1);
            @(negedge clk);
            chk("cpuif_req", bus.cpuif_req, (o <= req_last));
            if (o <= req_last) begin
                chk("cpuif_addr", bus.cpuif_addr, v.addr);
                chk("cpuif_req_is_wr", bus.cpuif_req_is_wr, v.is_wr);
                chk("cpuif_wr_data", bus.cpuif_wr_data, v.wdata);
                chk("cpuif_wr_biten", bus.cpuif_wr_biten, v.biten);
            end
            chk("rsp_valid", bus.rsp_valid, (o >= v.exp_rsp_off && o <= resp_end));
            if (o >= v.exp_rsp_off && o <= resp_end) begin
                chk("rsp_is_wr", bus.rsp_is_wr, v.is_wr);
                chk("rsp_rdata", bus.rsp_rdata, v.exp_rdata);
                chk("rsp_err", bus.rsp_err, v.exp_err);
                chk("rsp_timeout", bus.rsp_timeout, v.exp_to);
            end
            chk("cmd_ready", bus.cmd_ready, (o > resp_end));
            chk("stray_ack", bus.stray_ack, (o == late_off + 1) || (o == v.wrong + 1));
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t, limit 200000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[9];
        vec_t rv;

        idle_inputs();
        #2;
        chk("rst_cmd_ready", bus.cmd_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_cpuif_req", bus.cpuif_req, 0);
        chk("rst_stray", bus.stray_ack, 0);
        chk("rst_cpuif_addr", bus.cpuif_addr, 0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_cmd_ready", bus.cmd_ready, 1);

        //          wr  addr          wdata         biten         rdata         err s   d   wc late wrong ro ee  et  erdata
        vt[0] = mk(0, 32'h10, 32'h0,        32'h0,        32'hDEADBEEF, 0, 0,  0,  0, 0, -10, 2, 0, 0, 32'hDEADBEEF);
        vt[1] = mk(1, 32'h24, 32'h5A5A5A5A, 32'h0000FFFF, 32'h11111111, 1, 3,  0,  0, 0, -10, 5, 1, 0, 32'h0);
        vt[2] = mk(0, 32'h30, 32'h0,        32'h0,        32'hCAFEF00D, 0, 0,  20, 3, 1, -10, 8, 1, 1, 32'h0);
        vt[3] = mk(1, 32'h40, 32'h01234567, 32'hFFFFFFFF, 32'h0,        0, 0,  1,  5, 0, -10, 3, 0, 0, 32'h0);
        vt[4] = mk(0, 32'h44, 32'h0,        32'h0,        32'h12345678, 0, 0,  6,  0, 0, -10, 8, 0, 0, 32'h12345678);
        vt[5] = mk(0, 32'h48, 32'h0,        32'h0,        32'h0BADF00D, 1, 6,  0,  1, 0, -10, 8, 1, 0, 32'h0BADF00D);
        vt[6] = mk(1, 32'h4C, 32'hA0A0A0A0, 32'h00FF00FF, 32'h0,        0, 10, 0,  0, 1, -10, 8, 1, 1, 32'h0);
        vt[7] = mk(0, 32'h50, 32'h0,        32'h0,        32'hA5A5A5A5, 0, 1,  2,  0, 0, 2,   5, 0, 0, 32'hA5A5A5A5);
        vt[8] = mk(0, 32'h54, 32'h0,        32'h0,        32'h77777777, 0, 0,  7,  1, 0, -10, 8, 1, 1, 32'h0);
        for (int i = 0; i < 9; i++) run(vt[i]);

        for (int i = 0; i < 40; i++) begin
            rv.is_wr = 1'($urandom_range(0, 1));
            rv.addr = $urandom; rv.wdata = $urandom; rv.biten = $urandom;
            rv.rdata = $urandom; rv.err = 1'($urandom_range(0, 1));
            rv.stall = ($urandom_range(0, 7) == 7) ? 10 : $urandom_range(0, 6);
            rv.dly = $urandom_range(0, 7);
            rv.wait_c = $urandom_range(0, 3);
            rv = predict(rv);
            rv.late  = rv.exp_to && ($urandom_range(0, 1) == 1);
            rv.wrong = ($urandom_range(0, 2) == 0) ? $urandom_range(0, rv.exp_rsp_off - 1) : -10;
            run(rv);
        end

        // reset while waiting for a write ack, then the ack arrives late
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1; bus.cmd_is_wr = 1'b1; bus.cmd_addr = 32'h60;
        bus.cmd_wdata = 32'hFFFFFFFF; bus.cmd_biten = 32'hFFFFFFFF;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("rstseq_req", bus.cpuif_req, 1);
        @(posedge clk); #1;
        arst_n = 1'b0;
        #1;
        chk("rstseq_cmd_ready", bus.cmd_ready, 0);
        chk("rstseq_cpuif_req", bus.cpuif_req, 0);
        chk("rstseq_req_is_wr", bus.cpuif_req_is_wr, 0);
        chk("rstseq_addr", bus.cpuif_addr, 0);
        chk("rstseq_wr_data", bus.cpuif_wr_data, 0);
        chk("rstseq_wr_biten", bus.cpuif_wr_biten, 0);
        chk("rstseq_rsp_valid", bus.rsp_valid, 0);
        chk("rstseq_rsp_err", bus.rsp_err, 0);
        chk("rstseq_stray", bus.stray_ack, 0);
        @(posedge clk);
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
        chk("rstseq_ready_after", bus.cmd_ready, 1);
        @(posedge clk); #1;
        bus.cpuif_wr_ack = 1'b1;
        @(posedge clk); #1;
        bus.cpuif_wr_ack = 1'b0;
        @(negedge clk);
        chk("rstseq_stray_pulse", bus.stray_ack, 1);
        chk("rstseq_no_rsp", bus.rsp_valid, 0);
        @(negedge clk);
        chk("rstseq_stray_end", bus.stray_ack, 0);
        chk("rstseq_ready_end", bus.cmd_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
